// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter
// Registered arbiter for one slave port of the multilayer interconnect.
// It selects one of NUM_MASTERS AHB input stages using either fixed priority
// (index 0 highest) or round-robin order. A grant is held across SEQ/BUSY
// bursts and locked sequences, so bursts are never split and locks are never
// broken. The block also tracks the data-phase owner, which steers the
// slave-side write-data and response muxes.
//
// Ports
//   hclk        bus clock; all state changes on the rising edge
//   hresetn     asynchronous active-low reset
//   htrans      HTRANS of master i at [2i+1:2i]
//   hmastlock   HMASTLOCK of master i
//   hready      slave HREADYOUT; arbitration advances only when 1
//   bus_grant   one-hot address-phase grant (registered)
//   grant_id    binary index of the bus_grant owner (kept while no owner)
//   grant_valid bus_grant holds a valid owner
//   data_grant  one-hot data-phase owner (registered)
//   data_valid  the data phase in progress is a real transfer
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ARB_MODE    = 1
) (
    input  logic                             hclk,
    input  logic                             hresetn,
    input  logic [2*NUM_MASTERS-1:0]         htrans,
    input  logic [NUM_MASTERS-1:0]           hmastlock,
    input  logic                             hready,
    output logic [NUM_MASTERS-1:0]           bus_grant,
    output logic [$clog2(NUM_MASTERS)-1:0]   grant_id,
    output logic                             grant_valid,
    output logic [NUM_MASTERS-1:0]           data_grant,
    output logic                             data_valid
);

    localparam int ID_W = $clog2(NUM_MASTERS);
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_MASTERS - 1);
    localparam logic [ID_W:0]   NUM_EXT = (ID_W+1)'(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] req_s;
    logic                   any_req_s;
    logic [1:0]             owner_trans_s;
    logic                   owner_lock_s;
    logic                   hold_s;
    logic [ID_W:0]          start_s;
    logic [ID_W:0]          off_s;
    logic [ID_W:0]          sum_s;
    logic [NUM_MASTERS-1:0] rot_req_s;
    logic [ID_W-1:0]        win_id_s;

    logic [NUM_MASTERS-1:0] bus_grant_r;
    logic [ID_W-1:0]        grant_id_r;
    logic                   grant_valid_r;
    logic [NUM_MASTERS-1:0] data_grant_r;
    logic                   data_valid_r;
    logic [ID_W-1:0]        rr_ptr_r;

    function automatic logic [NUM_MASTERS-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NUM_MASTERS-1:0] oh;
        oh = {NUM_MASTERS{1'b0}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            oh[i] = (id == ID_W'(i));
        end
        return oh;
    endfunction

    // Request vector (NONSEQ or SEQ) and the owner's transfer type / lock.
    always_comb begin
        req_s         = {NUM_MASTERS{1'b0}};
        owner_trans_s = 2'b00;
        owner_lock_s  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req_s[i]      = htrans[2*i+1];
            owner_trans_s = owner_trans_s | (htrans[2*i +: 2] & {2{grant_id_r == ID_W'(i)}});
            owner_lock_s  = owner_lock_s | (hmastlock[i] & (grant_id_r == ID_W'(i)));
        end
        any_req_s = |req_s;
        // BUSY (01) and SEQ (11) both have bit 0 set: the owner is mid-burst.
        hold_s    = grant_valid_r & (owner_trans_s[0] | owner_lock_s);
    end

    // Winner search: rotate requests so the search starts at start_s, then take the lowest.
    always_comb begin
        if (ARB_MODE == 0) begin
            start_s = {(ID_W+1){1'b0}};
        end else begin
            // Explicit wrap so non-power-of-two master counts work.
            start_s = {1'b0, rr_ptr_r} + {{ID_W{1'b0}}, 1'b1};
            if (start_s >= NUM_EXT) begin
                start_s = {(ID_W+1){1'b0}};
            end else begin
                start_s = start_s;
            end
        end
        rot_req_s = NUM_MASTERS'({req_s, req_s} >> start_s);
        off_s     = {(ID_W+1){1'b0}};
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (rot_req_s[k]) begin
                off_s = (ID_W+1)'(k);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = start_s + off_s;
        if (sum_s >= NUM_EXT) begin
            sum_s = sum_s - NUM_EXT;
        end else begin
            sum_s = sum_s;
        end
        win_id_s = sum_s[ID_W-1:0];
    end

    // Address-phase grant, round-robin pointer and data-phase owner registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            bus_grant_r   <= {NUM_MASTERS{1'b0}};
            grant_id_r    <= {ID_W{1'b0}};
            grant_valid_r <= 1'b0;
            data_grant_r  <= {NUM_MASTERS{1'b0}};
            data_valid_r  <= 1'b0;
            rr_ptr_r      <= PTR_RST;
        end else if (hready) begin
            data_grant_r <= bus_grant_r;
            data_valid_r <= grant_valid_r & owner_trans_s[1];
            if (hold_s) begin
                bus_grant_r   <= bus_grant_r;
                grant_id_r    <= grant_id_r;
                grant_valid_r <= grant_valid_r;
                rr_ptr_r      <= rr_ptr_r;
            end else if (any_req_s) begin
                bus_grant_r   <= id_to_onehot(win_id_s);
                grant_id_r    <= win_id_s;
                grant_valid_r <= 1'b1;
                rr_ptr_r      <= win_id_s;
            end else begin
                bus_grant_r   <= {NUM_MASTERS{1'b0}};
                grant_id_r    <= grant_id_r;
                grant_valid_r <= 1'b0;
                rr_ptr_r      <= rr_ptr_r;
            end
        end else begin
            bus_grant_r   <= bus_grant_r;
            grant_id_r    <= grant_id_r;
            grant_valid_r <= grant_valid_r;
            data_grant_r  <= data_grant_r;
            data_valid_r  <= data_valid_r;
            rr_ptr_r      <= rr_ptr_r;
        end
    end

    assign bus_grant   = bus_grant_r;
    assign grant_id    = grant_id_r;
    assign grant_valid = grant_valid_r;
    assign data_grant  = data_grant_r;
    assign data_valid  = data_valid_r;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter
// Directed bench for ahb_rr_arbiter with three instances: 2-master round-robin,
// 4-master round-robin and 4-master fixed priority. Expected output vectors are
// queued when stimulus is applied and compared after the following clock edge.
module tb_ahb_rr_arbiter;

    logic        hclk;
    logic        hresetn;
    logic        hready;

    logic [3:0]  htrans2;
    logic [1:0]  lock2;
    logic [1:0]  bg2;
    logic [0:0]  gid2;
    logic        gv2;
    logic [1:0]  dg2;
    logic        dv2;

    logic [7:0]  htrans4;
    logic [3:0]  lock4;
    logic [3:0]  bg_r4, dg_r4, bg_f4, dg_f4;
    logic [1:0]  gid_r4, gid_f4;
    logic        gv_r4, dv_r4, gv_f4, dv_f4;

    int          checks = 0;
    int          errors = 0;
    string       tag_q[$];
    int          sel_q[$];
    logic [15:0] exp_q[$];

    ahb_rr_arbiter u_rr2 (
        .hclk(hclk), .hresetn(hresetn), .htrans(htrans2), .hmastlock(lock2), .hready(hready),
        .bus_grant(bg2), .grant_id(gid2), .grant_valid(gv2), .data_grant(dg2), .data_valid(dv2)
    );

    ahb_rr_arbiter #(.NUM_MASTERS(4), .ARB_MODE(1)) u_rr4 (
        .hclk(hclk), .hresetn(hresetn), .htrans(htrans4), .hmastlock(lock4), .hready(hready),
        .bus_grant(bg_r4), .grant_id(gid_r4), .grant_valid(gv_r4), .data_grant(dg_r4), .data_valid(dv_r4)
    );

    ahb_rr_arbiter #(.NUM_MASTERS(4), .ARB_MODE(0)) u_fx4 (
        .hclk(hclk), .hresetn(hresetn), .htrans(htrans4), .hmastlock(lock4), .hready(hready),
        .bus_grant(bg_f4), .grant_id(gid_f4), .grant_valid(gv_f4), .data_grant(dg_f4), .data_valid(dv_f4)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    function automatic logic [15:0] e2(input logic [1:0] bg, input logic gid, input logic gv,
                                       input logic [1:0] dg, input logic dv);
        return {9'd0, bg, gid, gv, dg, dv};
    endfunction

    function automatic logic [15:0] e4(input logic [3:0] bg, input logic [1:0] gid, input logic gv,
                                       input logic [3:0] dg, input logic dv);
        return {4'd0, bg, gid, gv, dg, dv};
    endfunction

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            0:       return {9'd0, bg2, gid2, gv2, dg2, dv2};
            1:       return {4'd0, bg_r4, gid_r4, gv_r4, dg_r4, dv_r4};
            default: return {4'd0, bg_f4, gid_f4, gv_f4, dg_f4, dv_f4};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [15:0] exp);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
    endtask

    task automatic check_all();
        string       t;
        int          s;
        logic [15:0] e;
        logic [15:0] o;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            o = observe(s);
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
        check_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hresetn = 1'b1;
        hready  = 1'b1;
        htrans2 = 4'b0000;
        lock2   = 2'b00;
        htrans4 = 8'h00;
        lock4   = 4'b0000;
        #2 hresetn = 1'b0;

        // Reset state of every instance
        expect_out("reset_rr2", 0, e2(2'b00, 1'b0, 1'b0, 2'b00, 1'b0));
        expect_out("reset_rr4", 1, e4(4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0));
        expect_out("reset_fx4", 2, e4(4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0));
        step();
        hresetn = 1'b1;

        // Test 1: reset in the middle of an M1 burst, then restart with M0
        htrans2 = 4'b1000;
        expect_out("t1_grant_m1", 0, e2(2'b10, 1'b1, 1'b1, 2'b00, 1'b0));
        step();
        htrans2 = 4'b1100;
        expect_out("t1_burst_seq", 0, e2(2'b10, 1'b1, 1'b1, 2'b10, 1'b1));
        step();
        hresetn = 1'b0;
        expect_out("t1_async_reset", 0, e2(2'b00, 1'b0, 1'b0, 2'b00, 1'b0));
        #2;
        check_all();
        htrans2 = 4'b0010;
        #1 hresetn = 1'b1;
        expect_out("t1_restart_m0", 0, e2(2'b01, 1'b0, 1'b1, 2'b00, 1'b0));
        step();
        expect_out("t1_m0_addr", 0, e2(2'b01, 1'b0, 1'b1, 2'b01, 1'b1));
        step();
        htrans2 = 4'b0000;
        expect_out("t1_idle", 0, e2(2'b00, 1'b0, 1'b0, 2'b01, 1'b0));
        step();
        expect_out("t1_drained", 0, e2(2'b00, 1'b0, 1'b0, 2'b00, 1'b0));
        step();

        // Test 2: round-robin fairness, all four masters NONSEQ every cycle
        htrans4 = 8'b10101010;
        expect_out("t2_rr_0", 1, e4(4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0));
        step();
        expect_out("t2_rr_1", 1, e4(4'b0010, 2'd1, 1'b1, 4'b0001, 1'b1));
        expect_out("t2_fixed_m0_only", 2, e4(4'b0001, 2'd0, 1'b1, 4'b0001, 1'b1));
        step();
        expect_out("t2_rr_2", 1, e4(4'b0100, 2'd2, 1'b1, 4'b0010, 1'b1));
        step();
        expect_out("t2_rr_3", 1, e4(4'b1000, 2'd3, 1'b1, 4'b0100, 1'b1));
        step();
        expect_out("t2_rr_wrap_0", 1, e4(4'b0001, 2'd0, 1'b1, 4'b1000, 1'b1));
        step();
        htrans4 = 8'h00;
        expect_out("t2_idle", 1, e4(4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0));
        step();
        expect_out("t2_rr_drained", 1, e4(4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0));
        expect_out("t2_fixed_drained", 2, e4(4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0));
        step();

        // Test 3: fixed priority, M1 and M3 request; M1 wins until it idles
        htrans4 = 8'b10001000;
        expect_out("t3_m1_first", 2, e4(4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0));
        step();
        expect_out("t3_m1_again", 2, e4(4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1));
        step();
        htrans4 = 8'b10000000;
        expect_out("t3_m3", 2, e4(4'b1000, 2'd3, 1'b1, 4'b0010, 1'b0));
        step();
        expect_out("t3_m3_addr", 2, e4(4'b1000, 2'd3, 1'b1, 4'b1000, 1'b1));
        step();
        htrans4 = 8'h00;
        expect_out("t3_idle_keeps_id", 2, e4(4'b0000, 2'd3, 1'b0, 4'b1000, 1'b0));
        step();
        expect_out("t3_drained", 2, e4(4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0));
        step();

        // Test 6: locked M2 keeps the grant over higher-priority M0
        htrans4 = 8'b00100000;
        lock4   = 4'b0100;
        expect_out("t6_m2_grant", 2, e4(4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0));
        step();
        htrans4 = 8'b00100010;
        expect_out("t6_lock_hold_1", 2, e4(4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1));
        step();
        expect_out("t6_lock_hold_2", 2, e4(4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1));
        step();
        htrans4 = 8'b00000010;
        lock4   = 4'b0000;
        expect_out("t6_m0_after_unlock", 2, e4(4'b0001, 2'd0, 1'b1, 4'b0100, 1'b0));
        step();
        expect_out("t6_m0_addr", 2, e4(4'b0001, 2'd0, 1'b1, 4'b0001, 1'b1));
        step();
        htrans4 = 8'h00;
        expect_out("t6_idle", 2, e4(4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0));
        step();

        // Test 4: M0 INCR4 burst; M1 requests during the SEQ beats
        htrans2 = 4'b0010;
        expect_out("t4_m0_grant", 0, e2(2'b01, 1'b0, 1'b1, 2'b00, 1'b0));
        step();
        expect_out("t4_m0_nonseq", 0, e2(2'b01, 1'b0, 1'b1, 2'b01, 1'b1));
        step();
        htrans2 = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            expect_out("t4_seq_hold", 0, e2(2'b01, 1'b0, 1'b1, 2'b01, 1'b1));
            step();
        end
        htrans2 = 4'b1000;
        expect_out("t4_m1_after_burst", 0, e2(2'b10, 1'b1, 1'b1, 2'b01, 1'b0));
        step();

        // Test 5: three wait states during an M1 beat freeze every output
        expect_out("t5_m1_addr", 0, e2(2'b10, 1'b1, 1'b1, 2'b10, 1'b1));
        step();
        htrans2 = 4'b0010;
        hready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out("t5_wait_frozen", 0, e2(2'b10, 1'b1, 1'b1, 2'b10, 1'b1));
            step();
        end
        hready = 1'b1;
        expect_out("t5_ready_m0", 0, e2(2'b01, 1'b0, 1'b1, 2'b10, 1'b0));
        step();
        expect_out("t5_m0_addr", 0, e2(2'b01, 1'b0, 1'b1, 2'b01, 1'b1));
        step();
        htrans2 = 4'b0000;
        expect_out("t5_idle", 0, e2(2'b00, 1'b0, 1'b0, 2'b01, 1'b0));
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
